// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester block.
//   arb_client_state_e : requester FSM states
//   *_DEF              : default values for the arb_client parameters
//   clog2()            : ceiling log2, used to size counters from parameters
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    XFER    = 3'd2,
    HOLD    = 3'd3,
    BACKOFF = 3'd4
  } arb_client_state_e;

  localparam int LEN_W_DEF       = 4;
  localparam int BACKOFF_CYC_DEF = 4;
  localparam int MAX_RETRY_DEF   = 3;
  localparam int DLY_CYC_DEF     = 2;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_client_timer.sv
// Loadable down-counter shared by the HOLD and BACKOFF waits.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value to load
//   zero      : counter is at zero; it stops there until the next load
module arb_client_timer
  import arb_pkg::*;
#(
  parameter int TMR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TMR_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/arb_client.sv
// Requester-side FSM for the single-grant arbiter (req/gnt/done/dly/tout).
// Takes a job from the upstream engine, requests the arbiter, runs a counted
// burst once granted, and retries with back-off after arbiter timeouts.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : job pulse, sampled only in IDLE
//   len, slow   : burst length (0 means 1) and delayed-release request
//   gnt, tout   : arbiter grant and timeout
//   req         : request to arbiter (REQ and XFER)
//   done, dly   : last-beat strobe and its delayed-release flag
//   busy        : FSM is not IDLE
//   xfer_valid  : a beat moves this cycle; beat_cnt is its 0-based index
//   ok, err     : one-cycle job completed / job abandoned pulses
// Every output is decoded from registers only.
module arb_client
  import arb_pkg::*;
#(
  parameter int LEN_W       = LEN_W_DEF,
  parameter int BACKOFF_CYC = BACKOFF_CYC_DEF,
  parameter int MAX_RETRY   = MAX_RETRY_DEF,
  parameter int DLY_CYC     = DLY_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             slow,
  input  logic             gnt,
  input  logic             tout,
  output logic             req,
  output logic             done,
  output logic             dly,
  output logic             busy,
  output logic             xfer_valid,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             ok,
  output logic             err
);

  localparam int RTY_W = clog2(MAX_RETRY + 1);
  localparam int TMR_W = clog2(((BACKOFF_CYC > DLY_CYC) ? BACKOFF_CYC : DLY_CYC) + 1);

  // The timer is loaded with N-1 so that a wait of N cycles ends on the
  // cycle in which it reads zero.
  localparam logic [TMR_W-1:0] BO_LOAD   = TMR_W'(BACKOFF_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(DLY_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  arb_client_state_e state_q, state_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  len_q;
  logic              slow_q;
  logic              job_latch;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_zero;
  logic              last_beat;
  logic              abort;

  arb_client_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign last_beat = (beat_q == (len_q - LEN_W'(1)));
  // The first beat may coincide with gnt already dropping; only later beats
  // treat a missing grant as a lost arbitration.
  assign abort     = tout || ((beat_q != '0) && !gnt);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    retry_d   = retry_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    job_latch = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          job_latch = 1'b1;
          retry_d   = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (tout) begin
          state_d  = BACKOFF;
          retry_d  = retry_q + RTY_W'(1);
          tmr_load = 1'b1;
          tmr_val  = BO_LOAD;
        end else if (gnt) begin
          state_d = XFER;
          beat_d  = '0;
        end
      end
      XFER: begin
        if (abort) begin
          state_d  = BACKOFF;
          beat_d   = '0;
          retry_d  = retry_q + RTY_W'(1);
          tmr_load = 1'b1;
          tmr_val  = BO_LOAD;
        end else if (last_beat) begin
          beat_d = '0;
          if (slow_q) begin
            state_d  = HOLD;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
          end else begin
            state_d = IDLE;
            ok_d    = 1'b1;
          end
        end else begin
          beat_d = beat_q + LEN_W'(1);
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d = IDLE;
          ok_d    = 1'b1;
        end
      end
      BACKOFF: begin
        if (retry_q == RTY_MAX) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (tmr_zero) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      retry_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      retry_q <= retry_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // Job descriptor; only read while a job is in flight.
  always_ff @(posedge clk) begin
    if (job_latch) begin
      len_q  <= (len == '0) ? LEN_W'(1) : len;
      slow_q <= slow;
    end
  end

  assign req        = (state_q == REQ) || (state_q == XFER);
  assign xfer_valid = (state_q == XFER);
  assign done       = xfer_valid && last_beat;
  assign dly        = done && slow_q;
  assign busy       = (state_q != IDLE);
  assign beat_cnt   = beat_q;
  assign ok         = ok_q;
  assign err        = err_q;

endmodule

// File: tb/tb_arb_client.sv
// Self-checking bench for arb_client. Each job pushes its expected beats and
// outcome into scoreboard queues; a monitor pops and compares them whenever
// the DUT shows a beat or an ok/err pulse. Scenario code adds cycle-exact
// timing checks on top.
module tb_arb_client;
  import arb_pkg::*;

  localparam int LEN_W       = 4;
  localparam int BACKOFF_CYC = 4;
  localparam int MAX_RETRY   = 3;
  localparam int DLY_CYC     = 2;

  localparam int OUT_OK  = 2;  // {ok,err} = 2'b10
  localparam int OUT_ERR = 1;  // {ok,err} = 2'b01

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len   = '0;
  logic             slow  = 1'b0;
  logic             gnt   = 1'b0;
  logic             tout  = 1'b0;
  logic             req, done, dly, busy, xfer_valid, ok, err;
  logic [LEN_W-1:0] beat_cnt;
  logic [10:0]      ov;

  typedef struct {
    int idx;
    bit last;
    bit dly;
  } beat_t;

  beat_t beat_q[$];
  int    out_q[$];
  int    n_checks   = 0;
  int    n_pass     = 0;
  int    beats_seen = 0;
  int    exp_beats  = 0;

  arb_client #(
    .LEN_W       (LEN_W),
    .BACKOFF_CYC (BACKOFF_CYC),
    .MAX_RETRY   (MAX_RETRY),
    .DLY_CYC     (DLY_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .slow       (slow),
    .gnt        (gnt),
    .tout       (tout),
    .req        (req),
    .done       (done),
    .dly        (dly),
    .busy       (busy),
    .xfer_valid (xfer_valid),
    .beat_cnt   (beat_cnt),
    .ok         (ok),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign ov = {req, done, dly, busy, xfer_valid, ok, err, beat_cnt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int l, input bit s);
    int eff;
    eff = (l == 0) ? 1 : l;
    for (int i = 0; i < eff; i++) begin
      beat_t b;
      b.idx  = i;
      b.last = (i == eff - 1);
      b.dly  = (i == eff - 1) && s;
      beat_q.push_back(b);
    end
    exp_beats += eff;
  endtask

  // Pulse start for one cycle; returns in the first cycle after start.
  task automatic issue(input int l, input bit s);
    start = 1'b1;
    len   = LEN_W'(l);
    slow  = s;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!req && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(req), 1);
  endtask

  task automatic wait_outcome(input string tag, input int exp);
    int n;
    n = 0;
    while (!(ok || err) && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'({ok, err}), exp);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("done_implies_xfer", 32'(done & ~xfer_valid), 0);
      check("dly_implies_done", 32'(dly & ~done), 0);
      check("ok_err_exclusive", 32'(ok & err), 0);
      if (xfer_valid) begin
        beats_seen++;
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 32'(beat_cnt) + 1, 0);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("beat_idx", 32'(beat_cnt), b.idx);
          check("beat_done", 32'(done), 32'(b.last));
          check("beat_dly", 32'(dly), 32'(b.dly));
        end
      end
      if (ok || err) begin
        if (out_q.size() == 0) begin
          check("outcome_unexpected", 32'({ok, err}), 0);
        end else begin
          int o;
          o = out_q.pop_front();
          check("outcome", 32'({ok, err}), o);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int win;

    // Reset state
    repeat (3) tick();
    check("reset_outputs", 32'(ov), 0);
    rst = 1'b0;
    tick();

    // Fast job: len=3, grant in the second REQ cycle
    push_beats(3, 1'b0);
    out_q.push_back(OUT_OK);
    issue(3, 1'b0);
    check("fast_req_after_start", 32'(req), 1);
    check("fast_busy", 32'(busy), 1);
    tick();
    check("fast_no_xfer_before_gnt", 32'(xfer_valid), 0);
    gnt = 1'b1;
    tick();
    check("fast_beat0_no_done", 32'(done), 0);
    tick();
    tick();
    check("fast_done_last", 32'(done), 1);
    check("fast_dly_low", 32'(dly), 0);
    tick();
    gnt = 1'b0;
    check("fast_ok", 32'(ok), 1);
    check("fast_busy_low", 32'(busy), 0);
    check("fast_req_low", 32'(req), 0);
    tick();
    check("fast_ok_one_cycle", 32'(ok), 0);

    // Slow job: len=1, done+dly then two HOLD cycles then ok
    push_beats(1, 1'b1);
    out_q.push_back(OUT_OK);
    issue(1, 1'b1);
    gnt = 1'b1;
    tick();
    check("slow_done", 32'(done), 1);
    check("slow_dly", 32'(dly), 1);
    tick();
    gnt = 1'b0;
    check("slow_hold1_req", 32'(req), 0);
    check("slow_hold1_busy", 32'(busy), 1);
    check("slow_hold1_ok", 32'(ok), 0);
    tick();
    check("slow_hold2_req", 32'(req), 0);
    check("slow_hold2_ok", 32'(ok), 0);
    tick();
    check("slow_ok", 32'(ok), 1);
    tick();

    // Timeout retry: two timeouts, grant on the third attempt
    push_beats(2, 1'b0);
    out_q.push_back(OUT_OK);
    issue(2, 1'b0);
    for (int a = 0; a < 2; a++) begin
      wait_req("retry_req");
      tout = 1'b1;
      tick();
      tout = 1'b0;
      n = 0;
      while (!req && n < 20) begin
        n++;
        tick();
      end
      check("retry_backoff_cycles", n, BACKOFF_CYC);
    end
    gnt = 1'b1;
    wait_outcome("retry_ok_no_err", OUT_OK);
    gnt = 1'b0;
    tick();

    // Exhaustion: timeout on every attempt
    out_q.push_back(OUT_ERR);
    issue(1, 1'b0);
    win = 0;
    for (int a = 0; a < MAX_RETRY; a++) begin
      wait_req("exh_req");
      win++;
      tout = 1'b1;
      tick();
      tout = 1'b0;
    end
    wait_outcome("exh_err", OUT_ERR);
    check("exh_req_windows", win, MAX_RETRY);
    check("exh_idle", 32'(busy), 0);
    tick();

    // gnt and tout together in REQ: timeout wins
    push_beats(1, 1'b0);
    out_q.push_back(OUT_OK);
    issue(1, 1'b0);
    gnt  = 1'b1;
    tout = 1'b1;
    tick();
    gnt  = 1'b0;
    tout = 1'b0;
    check("prio_no_xfer", 32'(xfer_valid), 0);
    check("prio_req_low", 32'(req), 0);
    check("prio_busy", 32'(busy), 1);
    wait_req("prio_retry_req");
    gnt = 1'b1;
    wait_outcome("prio_ok", OUT_OK);
    gnt = 1'b0;
    tick();

    // len=0 as one beat, minimum cycle time with grant already present
    push_beats(0, 1'b0);
    out_q.push_back(OUT_OK);
    gnt = 1'b1;
    issue(0, 1'b0);
    check("min_req_k1", 32'(req), 1);
    tick();
    check("min_done_k2", 32'(done), 1);
    check("len0_beat_idx", 32'(beat_cnt), 0);
    tick();
    check("min_ok_k3", 32'(ok), 1);
    gnt = 1'b0;
    tick();

    // start during XFER is ignored
    push_beats(4, 1'b0);
    out_q.push_back(OUT_OK);
    issue(4, 1'b0);
    gnt = 1'b1;
    tick();
    tick();
    start = 1'b1;
    len   = LEN_W'(2);
    slow  = 1'b1;
    tick();
    start = 1'b0;
    check("xfer_start_ignored_idx", 32'(beat_cnt), 2);
    tick();
    check("xfer_start_len_kept", 32'(done), 1);
    tick();
    check("xfer_start_ok", 32'(ok), 1);
    gnt = 1'b0;
    repeat (3) tick();
    check("xfer_start_no_new_job", 32'(busy), 0);

    // Reset mid-burst
    push_beats(4, 1'b0);
    out_q.push_back(OUT_OK);
    issue(4, 1'b0);
    gnt = 1'b1;
    tick();
    tick();
    check("rst_pre_beat1", 32'(beat_cnt), 1);
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", 32'(ov), 0);
    exp_beats -= beat_q.size();
    beat_q.delete();
    out_q.delete();
    gnt = 1'b0;
    tick();
    tick();
    check("rst_held_outputs", 32'(ov), 0);
    rst = 1'b0;
    tick();
    check("rst_idle_after_release", 32'(ov), 0);
    push_beats(2, 1'b0);
    out_q.push_back(OUT_OK);
    issue(2, 1'b0);
    gnt = 1'b1;
    wait_outcome("rst_clean_job_ok", OUT_OK);
    gnt = 1'b0;
    repeat (3) tick();

    check("sb_beats_drained", beat_q.size(), 0);
    check("sb_outcomes_drained", out_q.size(), 0);
    check("beats_total", beats_seen, exp_beats);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
